// File: rtl/aidan_mcnay_prime_sched_if.sv
// Handshake bundle between the user operand bus / prime datapath and the scheduler.
// The master side drives the operand and datapath result; the slave side is the scheduler.
interface aidan_mcnay_prime_sched_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             dp_done;
  logic             dp_is_prime;
  logic [WIDTH-1:0] op_data;
  logic             dp_start;
  logic             dp_abort;
  logic             result_valid;
  logic             is_prime;
  logic             timeout_err;

  modport master (
    output in_data, dp_done, dp_is_prime,
    input  op_data, dp_start, dp_abort, result_valid, is_prime, timeout_err
  );

  modport slave (
    input  in_data, dp_done, dp_is_prime,
    output op_data, dp_start, dp_abort, result_valid, is_prime, timeout_err
  );
endinterface

// File: rtl/aidan_mcnay_prime_sched.sv
// Prime-check scheduler: debounces the operand bus, launches the datapath,
// holds its result and aborts or relaunches whenever the operand changes.
module aidan_mcnay_prime_sched #(
  parameter int WIDTH          = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aidan_mcnay_prime_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e           state_q,      state_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic [15:0]      run_cnt_q,    run_cnt_d;
  logic [WIDTH-1:0] last_in_q,    last_in_d;
  logic [WIDTH-1:0] op_data_q,    op_data_d;
  logic             start_q,      start_d;
  logic             abort_q,      abort_d;
  logic             valid_q,      valid_d;
  logic             prime_q,      prime_d;
  logic             terr_q,       terr_d;
  logic             change;

  assign change    = (bus.in_data != last_in_q);
  assign last_in_d = bus.in_data;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    run_cnt_d    = run_cnt_q;
    op_data_d    = op_data_q;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    valid_d      = valid_q;
    prime_d      = prime_q;
    terr_d       = terr_q;

    unique case (state_q)
      ST_SETTLE: begin
        valid_d = 1'b0;
        if (change) begin
          settle_cnt_d = 8'd0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          op_data_d = bus.in_data;
          start_d   = 1'b1;
          run_cnt_d = 16'd0;
          state_d   = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end

      ST_RUN: begin
        // An operand change outranks a coincident result: that result is stale.
        if (change) begin
          abort_d      = 1'b1;
          settle_cnt_d = 8'd0;
          state_d      = ST_SETTLE;
        end else if (bus.dp_done) begin
          prime_d = bus.dp_is_prime;
          valid_d = 1'b1;
          terr_d  = 1'b0;
          state_d = ST_DONE;
        end else if (run_cnt_q == TIMEOUT_LAST) begin
          abort_d = 1'b1;
          terr_d  = 1'b1;
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        if (change) begin
          valid_d      = 1'b0;
          settle_cnt_d = 8'd0;
          state_d      = ST_SETTLE;
        end
      end

      default: state_d = ST_SETTLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= 8'd0;
      run_cnt_q    <= 16'd0;
      last_in_q    <= '0;
      op_data_q    <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      valid_q      <= 1'b0;
      prime_q      <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      run_cnt_q    <= run_cnt_d;
      last_in_q    <= last_in_d;
      op_data_q    <= op_data_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      valid_q      <= valid_d;
      prime_q      <= prime_d;
      terr_q       <= terr_d;
    end
  end

  assign bus.op_data      = op_data_q;
  assign bus.dp_start     = start_q;
  assign bus.dp_abort     = abort_q;
  assign bus.result_valid = valid_q;
  assign bus.is_prime     = prime_q;
  assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_aidan_mcnay_prime_sched.sv
// Directed bench for the prime scheduler; launches are checked against a queue
// of expected operands, everything else against hand-derived cycle timing.
module tb_aidan_mcnay_prime_sched;

  localparam int WIDTH   = 16;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_aborts = 0;

  logic [WIDTH-1:0] exp_q[$];

  aidan_mcnay_prime_sched_if #(.WIDTH(WIDTH)) bus ();

  aidan_mcnay_prime_sched #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op"},    32'(bus.op_data),      32'd0);
    check({tag, "_start"}, 32'(bus.dp_start),     32'd0);
    check({tag, "_abort"}, 32'(bus.dp_abort),     32'd0);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_prime"}, 32'(bus.is_prime),     32'd0);
    check({tag, "_terr"},  32'(bus.timeout_err),  32'd0);
  endtask

  // Result pulse lasting exactly one sampled edge.
  task automatic pulse_done(input logic prime);
    bus.dp_done     = 1'b1;
    bus.dp_is_prime = prime;
    tick(1);
    bus.dp_done     = 1'b0;
    bus.dp_is_prime = 1'b0;
  endtask

  // Scoreboard side: every launch must match the oldest expected operand.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.dp_start === 1'b1 || bus.dp_abort === 1'b1)) begin
      check("start_abort_exclusive", 32'(bus.dp_start & bus.dp_abort), 32'd0);
      if (bus.dp_abort === 1'b1) n_aborts++;
      if (bus.dp_start === 1'b1) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          check("sb_op_data", 32'(bus.op_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int starts_snap;

    rst_n           = 1'b1;
    bus.in_data     = '0;
    bus.dp_done     = 1'b0;
    bus.dp_is_prime = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    check_all_zero("reset");

    // Post-reset launch with operand 0.
    exp_q.push_back(16'd0);
    rst_n = 1'b1;
    tick(3);
    check("rst_launch_early", 32'(bus.dp_start), 32'd0);
    tick(1);
    check("rst_launch", 32'(bus.dp_start), 32'd1);
    check("rst_launch_op", 32'(bus.op_data), 32'd0);
    pulse_done(1'b0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd1);
    check("rst_result_prime", 32'(bus.is_prime), 32'd0);

    // Normal check of 13.
    bus.in_data = 16'd13;
    exp_q.push_back(16'd13);
    tick(4);
    check("n13_early", 32'(bus.dp_start), 32'd0);
    check("n13_invalid", 32'(bus.result_valid), 32'd0);
    tick(1);
    check("n13_launch", 32'(bus.dp_start), 32'd1);
    check("n13_op", 32'(bus.op_data), 32'd13);
    tick(2);
    check("n13_start_one_cycle", 32'(bus.dp_start), 32'd0);
    pulse_done(1'b1);
    check("n13_valid", 32'(bus.result_valid), 32'd1);
    check("n13_prime", 32'(bus.is_prime), 32'd1);
    starts_snap = n_starts;
    tick(20);
    check("n13_hold_valid", 32'(bus.result_valid), 32'd1);
    check("n13_hold_prime", 32'(bus.is_prime), 32'd1);
    check("n13_no_relaunch", 32'(n_starts), 32'(starts_snap));

    // Bounce 7,8,7,8 then settle on 8.
    starts_snap = n_starts;
    bus.in_data = 16'd7; tick(2);
    check("bounce_invalid", 32'(bus.result_valid), 32'd0);
    bus.in_data = 16'd8; tick(2);
    bus.in_data = 16'd7; tick(2);
    bus.in_data = 16'd8;
    exp_q.push_back(16'd8);
    check("bounce_no_start", 32'(n_starts), 32'(starts_snap));
    tick(4);
    check("bounce_early", 32'(bus.dp_start), 32'd0);
    tick(1);
    check("bounce_launch", 32'(bus.dp_start), 32'd1);
    check("bounce_op", 32'(bus.op_data), 32'd8);
    check("bounce_one_start", 32'(n_starts), 32'(starts_snap));
    pulse_done(1'b0);

    // Operand change coincident with dp_done during RUN.
    bus.in_data = 16'd97;
    exp_q.push_back(16'd97);
    tick(5);
    check("r97_launch", 32'(bus.dp_start), 32'd1);
    tick(1);
    bus.in_data     = 16'd98;
    bus.dp_done     = 1'b1;
    bus.dp_is_prime = 1'b1;
    exp_q.push_back(16'd98);
    tick(1);
    bus.dp_done     = 1'b0;
    bus.dp_is_prime = 1'b0;
    check("r98_abort", 32'(bus.dp_abort), 32'd1);
    check("r98_valid", 32'(bus.result_valid), 32'd0);
    check("r98_op_held", 32'(bus.op_data), 32'd97);
    tick(1);
    check("r98_abort_one_cycle", 32'(bus.dp_abort), 32'd0);
    check("r98_done_discarded", 32'(bus.result_valid), 32'd0);
    tick(2);
    check("r98_early", 32'(bus.dp_start), 32'd0);
    tick(1);
    check("r98_launch", 32'(bus.dp_start), 32'd1);
    check("r98_op", 32'(bus.op_data), 32'd98);
    pulse_done(1'b0);
    check("r98_valid_after", 32'(bus.result_valid), 32'd1);

    // Timeout after TIMEOUT edges in RUN, then a clean run clears the flag.
    bus.in_data = 16'd200;
    exp_q.push_back(16'd200);
    tick(5);
    check("to_launch", 32'(bus.dp_start), 32'd1);
    tick(TIMEOUT - 1);
    check("to_early", 32'(bus.dp_abort), 32'd0);
    tick(1);
    check("to_abort", 32'(bus.dp_abort), 32'd1);
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_valid", 32'(bus.result_valid), 32'd0);
    tick(1);
    check("to_abort_one_cycle", 32'(bus.dp_abort), 32'd0);
    check("to_err_sticky", 32'(bus.timeout_err), 32'd1);
    bus.in_data = 16'd211;
    exp_q.push_back(16'd211);
    tick(5);
    check("to2_launch", 32'(bus.dp_start), 32'd1);
    check("to2_err_still", 32'(bus.timeout_err), 32'd1);
    pulse_done(1'b1);
    check("to2_err_clear", 32'(bus.timeout_err), 32'd0);
    check("to2_valid", 32'(bus.result_valid), 32'd1);
    check("to2_prime", 32'(bus.is_prime), 32'd1);

    // Asynchronous reset while in RUN.
    bus.in_data = 16'd3;
    exp_q.push_back(16'd3);
    tick(5);
    check("ar_launch", 32'(bus.dp_start), 32'd1);
    tick(1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    tick(1);
    exp_q.push_back(16'd3);
    rst_n = 1'b1;
    pulse_done(1'b1);
    check("ar_done_ignored_valid", 32'(bus.result_valid), 32'd0);
    check("ar_done_ignored_prime", 32'(bus.is_prime), 32'd0);
    check("ar_no_abort", 32'(bus.dp_abort), 32'd0);
    tick(3);
    check("ar_early", 32'(bus.dp_start), 32'd0);
    tick(1);
    check("ar_launch2", 32'(bus.dp_start), 32'd1);
    check("ar_op", 32'(bus.op_data), 32'd3);
    pulse_done(1'b1);
    check("ar_valid", 32'(bus.result_valid), 32'd1);

    tick(2);
    check("total_starts", 32'(n_starts), 32'd9);
    check("total_aborts", 32'(n_aborts), 32'd2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
